// File: rtl/lcd_cmd_host.sv
// Command-side initiator for the LCD controller: walks a command ROM script,
// issues each command under the busy handshake, then waits for done after the write.
//
// state    | meaning
// IDLE     | waiting for start after reset
// WAITRDY  | waiting for the controller to drop busy after its image load
// FETCH    | command ROM read strobe (CROM_EN low)
// LATCH    | capture ROM data into the command register
// ISSUE    | wait for busy low, then strobe the command
// WAITDONE | write issued, waiting for done
// FIN      | script completed
// ERR      | watchdog timeout or ROM overrun
module lcd_cmd_host #(
  parameter int CMD_AW = 6,
  parameter int TO_W   = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              CROM_EN,
  output logic [CMD_AW-1:0] CROM_A,
  input  logic [2:0]        CROM_Q,
  input  logic              busy,
  input  logic              done,
  output logic [2:0]        cmd,
  output logic              cmd_valid,
  output logic              host_busy,
  output logic              finished,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [CMD_AW:0]   cmd_cnt
);

  typedef enum logic [2:0] {
    IDLE, WAITRDY, FETCH, LATCH, ISSUE, WAITDONE, FIN, ERR
  } state_t;

  // The wait that started at zero times out on its (2^TO_W-1)th cycle.
  localparam logic [TO_W-1:0]   WD_LAST   = {{(TO_W-1){1'b1}}, 1'b0};
  localparam logic [CMD_AW-1:0] ADDR_LAST = '1;
  localparam logic [CMD_AW:0]   CNT_MAX   = '1;

  state_t            state, state_n;
  logic [TO_W-1:0]   wd, wd_n;
  logic [2:0]        cmd_reg, cmd_reg_n, cmd_n;
  logic [CMD_AW-1:0] addr_n;
  logic [CMD_AW:0]   cnt_n;
  logic [1:0]        err_code_n;
  logic              cmd_valid_n;
  logic              wd_expired;

  always_comb begin
    state_n     = state;
    addr_n      = CROM_A;
    cmd_reg_n   = cmd_reg;
    cmd_n       = cmd;
    cmd_valid_n = 1'b0;
    cnt_n       = cmd_cnt;
    wd_n        = '0;
    err_code_n  = err_code;
    wd_expired  = (wd == WD_LAST);
    case (state)
      IDLE, FIN, ERR: begin
        if (start) begin
          state_n    = WAITRDY;
          addr_n     = '0;
          cnt_n      = '0;
          err_code_n = 2'b00;
        end
      end
      WAITRDY: begin
        if (!busy) begin
          state_n = FETCH;
        end else if (wd_expired) begin
          state_n    = ERR;
          err_code_n = 2'b01;
        end else begin
          wd_n = wd + TO_W'(1);
        end
      end
      FETCH: state_n = LATCH;
      LATCH: begin
        cmd_reg_n = CROM_Q;
        state_n   = ISSUE;
      end
      ISSUE: begin
        if (!busy) begin
          cmd_n       = cmd_reg;
          cmd_valid_n = 1'b1;
          if (cmd_cnt != CNT_MAX) cnt_n = cmd_cnt + (CMD_AW+1)'(1);
          if (cmd_reg == 3'd0) begin
            state_n = WAITDONE;
          end else if (CROM_A == ADDR_LAST) begin
            state_n    = ERR;
            err_code_n = 2'b10;
          end else begin
            addr_n  = CROM_A + CMD_AW'(1);
            state_n = FETCH;
          end
        end else if (wd_expired) begin
          state_n    = ERR;
          err_code_n = 2'b01;
        end else begin
          wd_n = wd + TO_W'(1);
        end
      end
      WAITDONE: begin
        if (done) begin
          state_n = FIN;
        end else if (wd_expired) begin
          state_n    = ERR;
          err_code_n = 2'b01;
        end else begin
          wd_n = wd + TO_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      CROM_EN   <= 1'b1;
      CROM_A    <= '0;
      cmd_reg   <= '0;
      cmd       <= '0;
      cmd_valid <= 1'b0;
      host_busy <= 1'b0;
      finished  <= 1'b0;
      err       <= 1'b0;
      err_code  <= '0;
      cmd_cnt   <= '0;
      wd        <= '0;
    end else begin
      state     <= state_n;
      CROM_EN   <= (state_n != FETCH);
      CROM_A    <= addr_n;
      cmd_reg   <= cmd_reg_n;
      cmd       <= cmd_n;
      cmd_valid <= cmd_valid_n;
      host_busy <= !(state_n inside {IDLE, FIN, ERR});
      finished  <= (state_n == FIN);
      err       <= (state_n == ERR);
      err_code  <= err_code_n;
      cmd_cnt   <= cnt_n;
      wd        <= wd_n;
    end
  end

endmodule

// File: tb/tb_lcd_cmd_host.sv
// Bench for lcd_cmd_host: two instances (default and CMD_AW=2/TO_W=4) against a
// script-level model of the expected strobe sequence plus directed timing literals.
module tb_lcd_cmd_host;
  logic clk = 1'b0, reset = 1'b1, busy = 1'b1, done = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0;
  always #5 clk = ~clk;

  logic       en_a, cv_a, hb_a, fin_a, err_a;
  logic [5:0] a_a;
  logic [2:0] q_a, cmd_a;
  logic [1:0] ec_a;
  logic [6:0] cnt_a;
  logic       en_b, cv_b, hb_b, fin_b, err_b;
  logic [1:0] a_b;
  logic [2:0] q_b, cmd_b;
  logic [1:0] ec_b;
  logic [2:0] cnt_b;

  lcd_cmd_host #(.CMD_AW(6), .TO_W(10)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .CROM_EN(en_a), .CROM_A(a_a),
    .CROM_Q(q_a), .busy(busy), .done(done), .cmd(cmd_a), .cmd_valid(cv_a),
    .host_busy(hb_a), .finished(fin_a), .err(err_a), .err_code(ec_a), .cmd_cnt(cnt_a));

  lcd_cmd_host #(.CMD_AW(2), .TO_W(4)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .CROM_EN(en_b), .CROM_A(a_b),
    .CROM_Q(q_b), .busy(busy), .done(done), .cmd(cmd_b), .cmd_valid(cv_b),
    .host_busy(hb_b), .finished(fin_b), .err(err_b), .err_code(ec_b), .cmd_cnt(cnt_b));

  logic [2:0] rom [2][64];
  always @(posedge clk) begin
    if (!en_a) q_a <= rom[0][a_a];
    if (!en_b) q_b <= rom[1][{4'b0, a_b}];
  end

  logic       cv [2], fin [2], er [2], hb [2], en [2];
  logic [2:0] cmdv [2];
  logic [6:0] cnt [2];
  logic [1:0] ec [2];
  logic [5:0] addr [2];
  always_comb begin
    cv[0] = cv_a;  fin[0] = fin_a; er[0] = err_a; hb[0] = hb_a; en[0] = en_a;
    cmdv[0] = cmd_a; cnt[0] = cnt_a; ec[0] = ec_a; addr[0] = a_a;
    cv[1] = cv_b;  fin[1] = fin_b; er[1] = err_b; hb[1] = hb_b; en[1] = en_b;
    cmdv[1] = cmd_b; cnt[1] = {4'b0, cnt_b}; ec[1] = ec_b; addr[1] = {4'b0, a_b};
  end

  int checks = 0, passed = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%0d required=%0d", name, act, exp);
  endtask

  // Script model: the strobe list a run must produce, derived from ROM contents.
  int         exp_n [2], idx [2], exp_ovr [2], last_cyc [2];
  int         strobe_cyc [2][64];
  logic [2:0] exp_cmd [2][64];
  logic [2:0] last_cmd [2];

  task automatic build_script(input int i, input int aw);
    logic [2:0] c;
    exp_n[i] = 0; idx[i] = 0; exp_ovr[i] = 0;
    for (int k = 0; k < (1 << aw); k++) begin
      c = rom[i][k];
      exp_cmd[i][exp_n[i]] = c;
      exp_n[i]++;
      if (c == 3'd0) break;
      if (k == (1 << aw) - 1) exp_ovr[i] = 1;
    end
  endtask

  logic rst_prev = 1'b1, busy_prev = 1'b1;
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst_prev) last_cmd[i] = 3'd0;
      if (cv[i]) begin
        chk("strobe_expected", idx[i] < exp_n[i], 1);
        if (idx[i] < exp_n[i]) begin
          chk("strobe_cmd", cmdv[i], exp_cmd[i][idx[i]]);
          chk("strobe_cnt", cnt[i], idx[i] + 1);
          chk("strobe_busy_low", busy_prev, 0);
          if (idx[i] > 0) chk("strobe_gap_ge3", (cyc - last_cyc[i]) >= 3, 1);
          strobe_cyc[i][idx[i]] = cyc;
          last_cyc[i] = cyc;
          idx[i]++;
        end
        last_cmd[i] = cmdv[i];
      end else begin
        chk("cmd_hold", cmdv[i], last_cmd[i]);
      end
      if (!er[i]) chk("err_code_idle", ec[i], 0);
      chk("status_excl", (int'(fin[i]) + int'(er[i]) + int'(hb[i])) <= 1, 1);
    end
    rst_prev  = reset;
    busy_prev = busy;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int i);
    if (i == 0) start_a = 1'b1; else start_b = 1'b1;
    tick(1);
    start_a = 1'b0; start_b = 1'b0;
  endtask

  task automatic begin_run(input int i);
    build_script(i, (i == 0) ? 6 : 2);
    pulse_start(i);
  endtask

  task automatic wait_strobe(input int i, input logic [2:0] v, input int max, output int n);
    n = 0;
    do begin tick(1); n++; end while (!(cv[i] && cmdv[i] == v) && n < max);
    chk("strobe_seen", {cv[i], cmdv[i]}, {1'b1, v});
  endtask

  task automatic wait_flag(input int i, input bit want_err, input int max, output int n);
    n = 0;
    do begin tick(1); n++; end while (!(want_err ? er[i] : fin[i]) && n < max);
    chk("flag_seen", want_err ? er[i] : fin[i], 1);
  endtask

  task automatic chk_reset(input int i);
    chk("rst_crom_en", en[i], 1);    chk("rst_crom_a", addr[i], 0);
    chk("rst_cmd", cmdv[i], 0);      chk("rst_cmd_valid", cv[i], 0);
    chk("rst_host_busy", hb[i], 0);  chk("rst_finished", fin[i], 0);
    chk("rst_err", er[i], 0);        chk("rst_err_code", ec[i], 0);
    chk("rst_cmd_cnt", cnt[i], 0);
  endtask

  initial begin
    #50000;
    $display("FAIL global_timeout actual=1 required=0");
    $fatal(1);
  end

  initial begin
    int n;
    for (int i = 0; i < 64; i++) begin rom[0][i] = 3'd7; rom[1][i] = 3'd7; end
    rom[0][0] = 3'd1; rom[0][1] = 3'd3; rom[0][2] = 3'd5; rom[0][3] = 3'd0;
    rom[1][0] = 3'd2; rom[1][1] = 3'd0;
    tick(3);
    chk_reset(0); chk_reset(1);
    reset = 1'b0;
    tick(1);

    // basic script, busy released 5 cycles after start
    begin_run(0);
    chk("model_len_basic", exp_n[0], 4);
    chk("hb_after_start", hb[0], 1);
    tick(4); busy = 1'b0;
    wait_strobe(0, 3'd1, 20, n); chk("first_strobe_latency", n, 4);
    wait_strobe(0, 3'd0, 20, n);
    tick(70);
    chk("write_strobe_offset", strobe_cyc[0][3] - strobe_cyc[0][0], 9);
    chk("waitdone_no_fin", fin[0], 0);
    done = 1'b1;
    wait_flag(0, 1'b0, 5, n); chk("fin_latency", n, 1);
    done = 1'b0;
    chk("basic_cnt", cnt[0], 4); chk("basic_err_code", ec[0], 0);
    chk("basic_hb", hb[0], 0);   chk("basic_strobes", idx[0], 4);

    // busy stall before the second command; start from FIN
    begin_run(0);
    chk("fin_cleared", fin[0], 0); chk("cnt_cleared", cnt[0], 0);
    wait_strobe(0, 3'd1, 20, n);
    busy = 1'b1; tick(20); busy = 1'b0; tick(1);
    chk("stall_release", {cv[0], cmdv[0]}, {1'b1, 3'd3});
    wait_strobe(0, 3'd0, 20, n);
    tick(3); done = 1'b1;
    wait_flag(0, 1'b0, 5, n); done = 1'b0;
    chk("stall_cnt", cnt[0], 4); chk("stall_strobes", idx[0], 4);

    // start pulses in FETCH and WAITDONE are ignored
    begin_run(0);
    wait_strobe(0, 3'd1, 20, n);
    pulse_start(0);
    wait_strobe(0, 3'd0, 20, n);
    pulse_start(0);
    tick(2); done = 1'b1;
    wait_flag(0, 1'b0, 5, n); done = 1'b0;
    tick(1);
    chk("ign_cnt", cnt[0], 4); chk("ign_strobes", idx[0], 4);

    // reset during ISSUE of the second command, then replay
    begin_run(0);
    wait_strobe(0, 3'd1, 20, n);
    tick(2);
    reset = 1'b1; exp_n[0] = 0; idx[0] = 0;
    tick(1);
    chk_reset(0);
    reset = 1'b0;
    tick(1);
    begin_run(0);
    wait_strobe(0, 3'd0, 40, n);
    tick(2); done = 1'b1;
    wait_flag(0, 1'b0, 5, n); done = 1'b0;
    tick(1);
    chk("replay_cnt", cnt[0], 4); chk("replay_strobes", idx[0], 4);

    // watchdog in WAITDONE, TO_W=4
    begin_run(1);
    wait_strobe(1, 3'd0, 30, n);
    wait_flag(1, 1'b1, 30, n);
    chk("timeout_cycles", n, 15); chk("timeout_code", ec[1], 1);
    chk("timeout_hb", hb[1], 0);  chk("timeout_cnt", cnt[1], 2);
    tick(5);
    chk("timeout_err_hold", er[1], 1); chk("timeout_strobes", idx[1], 2);

    // ROM overrun, CMD_AW=2; start from ERR
    rom[1][0] = 3'd1; rom[1][1] = 3'd2; rom[1][2] = 3'd3; rom[1][3] = 3'd4;
    begin_run(1);
    chk("model_ovr", exp_ovr[1], 1);
    chk("err_cleared", er[1], 0); chk("err_code_cleared", ec[1], 0);
    wait_strobe(1, 3'd4, 30, n);
    chk("ovr_err", er[1], 1); chk("ovr_code", ec[1], 2); chk("ovr_cnt", cnt[1], 4);
    tick(5);
    chk("ovr_strobes", idx[1], 4); chk("ovr_err_hold", er[1], 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
